// File: rtl/ucode_pkg.sv
// Shared types and constants for the microcoded control unit: sequencing field,
// microword layout, RISC-V opcodes, initial microprogram and dispatch table.
package ucode_pkg;

  typedef enum logic [1:0] {
    NEXT  = 2'b00,
    JUMP  = 2'b01,
    DISP  = 2'b10,
    FETCH = 2'b11
  } seq_e;

  // Constants are held at the widest supported geometry and truncated per instance.
  localparam int UCODE_MAX_DEPTH = 64;
  localparam int CTRL_MAX_W      = 32;
  localparam int UADDR_MAX_W     = 8;

  typedef struct packed {
    logic [CTRL_MAX_W-1:0]  ctrl;
    seq_e                   seq;
    logic [UADDR_MAX_W-1:0] next;
  } microword_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  function automatic microword_t uw(logic [CTRL_MAX_W-1:0] c, seq_e s, int n);
    return '{ctrl: c, seq: s, next: UADDR_MAX_W'(n)};
  endfunction

  // ctrl bits: 17 reg_we, 16:15 wb_sel, 14 alu_src_a, 13:12 alu_src_b, 11:10 alu_op,
  // 9 mem_we, 8 mem_re, 7 ir_we, 6 pc_we, 5 pc_cond, 4 pc_src, 3 iord, 2 a_we, 1 b_we, 0 alu_out_we.
  // The jal tail jumps to word 63; a 32-deep store folds that onto the trap word,
  // which also returns to fetch.
  localparam microword_t UCODE_INIT [UCODE_MAX_DEPTH] = '{
    0:       uw(32'h011C0, NEXT,  0),   // fetch
    1:       uw(32'h03007, DISP,  0),   // decode
    2:       uw(32'h06001, NEXT,  0),   // lw address
    3:       uw(32'h00108, NEXT,  0),   // lw memory read
    4:       uw(32'h28000, FETCH, 0),   // lw writeback
    5:       uw(32'h06001, NEXT,  0),   // sw address
    6:       uw(32'h00208, FETCH, 0),   // sw memory write
    7:       uw(32'h04801, NEXT,  0),   // R execute
    8:       uw(32'h20000, FETCH, 0),   // ALU writeback
    9:       uw(32'h06C01, JUMP,  8),   // I execute
    10:      uw(32'h04430, FETCH, 0),   // beq
    11:      uw(32'h30050, JUMP,  63),  // jal
    31:      uw(32'h00050, FETCH, 0),   // trap
    63:      uw(32'h00001, NEXT,  0),   // jal tail
    default: uw(32'h00000, FETCH, 0)
  };

  typedef struct packed {
    logic                   valid;
    logic [6:0]             opcode;
    logic [UADDR_MAX_W-1:0] target;
  } disp_entry_t;

  localparam int DISP_N = 8;

  // Entry 6 duplicates lw and is shadowed by entry 0.
  localparam disp_entry_t DISP_TABLE [DISP_N] = '{
    '{1'b1, OP_LOAD,  8'd2},
    '{1'b1, OP_STORE, 8'd5},
    '{1'b1, OP_R,     8'd7},
    '{1'b1, OP_I,     8'd9},
    '{1'b1, OP_BEQ,   8'd10},
    '{1'b1, OP_JAL,   8'd11},
    '{1'b1, OP_LOAD,  8'd31},
    '{1'b0, 7'd0,     8'd0}
  };

endpackage

// File: rtl/ucode_dispatch.sv
// Combinational opcode lookup over DISP_TABLE; lowest matching index wins.
module ucode_dispatch
  import ucode_pkg::*;
#(
  parameter int OP_W    = 7,
  parameter int UADDR_W = 5
) (
  input  logic [OP_W-1:0]    opcode,
  output logic               hit,
  output logic [UADDR_W-1:0] target
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    hit    = 1'b0;
    target = '0;
    for (int i = DISP_N - 1; i >= 0; i--) begin
      if (DISP_TABLE[i].valid && opcode == OP_W'(DISP_TABLE[i].opcode)) begin
        hit    = 1'b1;
        target = UADDR_W'(DISP_TABLE[i].target);
      end
    end
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Microcoded control unit: uPC, microcode store, next-address logic and write-enable masking.
// UCODE_LOADABLE_EN makes the store a writable register array with load_en/load_addr/load_data.
module microcode_sequencer
  import ucode_pkg::*;
#(
  parameter int                UADDR_W   = 5,
  parameter int                CTRL_W    = 18,
  parameter int                OP_W      = 7,
  parameter int                TRAP_ADDR = 31,
  parameter logic [CTRL_W-1:0] WE_MASK   = CTRL_W'(18'b100000001000000000)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [OP_W-1:0]             opcode,
  input  logic                        stall,
`ifdef UCODE_LOADABLE_EN
  input  logic                        load_en,
  input  logic [UADDR_W-1:0]          load_addr,
  input  logic [CTRL_W+2+UADDR_W-1:0] load_data,
`endif
  output logic [CTRL_W-1:0]           ctrl,
  output logic [UADDR_W-1:0]          upc,
  output logic                        fetch,
  output logic                        illegal_op
);

  localparam int DEPTH = 1 << UADDR_W;

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    seq_e               seq;
    logic [UADDR_W-1:0] next;
  } uword_t;

  function automatic uword_t init_word(int a);
    uword_t w;
    w = '{ctrl: '0, seq: FETCH, next: '0};
    if (a < UCODE_MAX_DEPTH) begin
      w.ctrl = CTRL_W'(UCODE_INIT[a].ctrl);
      w.seq  = UCODE_INIT[a].seq;
      w.next = UADDR_W'(UCODE_INIT[a].next);
    end
    return w;
  endfunction

  uword_t store [DEPTH];

`ifdef UCODE_LOADABLE_EN
  // NOTE: this array is reset on purpose -- reset must restore the initial microprogram.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= init_word(i);
    end else if (load_en) begin
      store[load_addr] <= uword_t'(load_data);
    end
  end
`else
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign store[g] = init_word(g);
  end
`endif

  uword_t             cur;
  logic               disp_hit;
  logic [UADDR_W-1:0] disp_target;
  logic [UADDR_W-1:0] upc_nxt;
  logic               miss;

  assign cur = store[upc];

  ucode_dispatch #(
    .OP_W    (OP_W),
    .UADDR_W (UADDR_W)
  ) u_dispatch (
    .opcode (opcode),
    .hit    (disp_hit),
    .target (disp_target)
  );

  always_comb begin
    upc_nxt = upc;
    miss    = 1'b0;
    case (cur.seq)
      NEXT:  upc_nxt = upc + UADDR_W'(1);
      JUMP:  upc_nxt = cur.next;
      DISP: begin
        if (disp_hit) begin
          upc_nxt = disp_target;
        end else begin
          upc_nxt = UADDR_W'(TRAP_ADDR);
          miss    = 1'b1;
        end
      end
      FETCH: upc_nxt = '0;
    endcase
  end

  // A stalled cycle re-evaluates dispatch, so the opcode present on release is the one used.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upc        <= '0;
      illegal_op <= 1'b0;
    end else if (!stall) begin
      // NOTE: non-blocking so both registers update from the same pre-edge values.
      upc        <= upc_nxt;
      illegal_op <= miss;
    end
  end

  assign ctrl  = cur.ctrl & ~(stall ? WE_MASK : '0);
  assign fetch = (upc == '0);

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench: two instances (default and 6-bit/24-bit) share opcode and stall;
// stimulus queues expected state per cycle, a monitor compares on the falling edge.
module tb_microcode_sequencer;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RR  = 7'b0110011;
  localparam logic [6:0] II  = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic        stall = 1'b0;

  logic [17:0] u5_ctrl;
  logic [4:0]  u5_upc;
  logic        u5_fetch, u5_ill;
  logic [23:0] u6_ctrl;
  logic [5:0]  u6_upc;
  logic        u6_fetch, u6_ill;

`ifdef UCODE_LOADABLE_EN
  logic        ld_en = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
`endif

  always #5 clk = ~clk;

  microcode_sequencer u5 (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .stall      (stall),
`ifdef UCODE_LOADABLE_EN
    .load_en    (1'b0),
    .load_addr  (5'd0),
    .load_data  (25'd0),
`endif
    .ctrl       (u5_ctrl),
    .upc        (u5_upc),
    .fetch      (u5_fetch),
    .illegal_op (u5_ill)
  );

  microcode_sequencer #(
    .UADDR_W (6),
    .CTRL_W  (24),
    .WE_MASK (24'h020200)
  ) u6 (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .stall      (stall),
`ifdef UCODE_LOADABLE_EN
    .load_en    (ld_en),
    .load_addr  (ld_addr),
    .load_data  (ld_data),
`endif
    .ctrl       (u6_ctrl),
    .upc        (u6_upc),
    .fetch      (u6_fetch),
    .illegal_op (u6_ill)
  );

  typedef struct {
    bit          w6;
    logic [5:0]  upc;
    logic [23:0] ctrl;
    logic        ill;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event chk_now;

  initial begin
    forever begin
      @(negedge clk or chk_now);
      while (q.size() > 0) begin
        exp_t        it;
        logic [5:0]  a_upc;
        logic [23:0] a_ctrl;
        logic        a_f, a_i;
        it = q.pop_front();
        if (it.w6) begin
          a_upc = u6_upc; a_ctrl = u6_ctrl; a_f = u6_fetch; a_i = u6_ill;
        end else begin
          a_upc = {1'b0, u5_upc}; a_ctrl = {6'd0, u5_ctrl}; a_f = u5_fetch; a_i = u5_ill;
        end
        checks++;
        if ({a_upc, a_ctrl, a_f, a_i} !== {it.upc, it.ctrl, (it.upc == 6'd0), it.ill}) begin
          errors++;
          $display("FAIL %s (dut%0d): got upc=%0d ctrl=%h fetch=%b ill=%b, want upc=%0d ctrl=%h fetch=%b ill=%b",
                   it.name, it.w6 ? 6 : 5, a_upc, a_ctrl, a_f, a_i,
                   it.upc, it.ctrl, (it.upc == 6'd0), it.ill);
        end
      end
    end
  end

  task automatic step(input logic s, input logic [6:0] op);
    @(posedge clk);
    #1;
    stall  = s;
    opcode = op;
  endtask

  task automatic e1(input bit w6, input int u, input logic [23:0] c, input logic ill, input string nm);
    exp_t it;
    it.w6 = w6; it.upc = 6'(u); it.ctrl = c; it.ill = ill; it.name = nm;
    q.push_back(it);
  endtask

  task automatic e(input int u, input logic [23:0] c, input logic ill, input string nm);
    e1(1'b0, u, c, ill, nm);
    e1(1'b1, u, c, ill, nm);
  endtask

  task automatic async_reset(input string nm);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    e(0, 24'h011C0, 1'b0, nm);
    ->chk_now;
    @(posedge clk);
    #1;
    e(0, 24'h011C0, 1'b0, {nm, "_held"});
    stall   = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    step(0, '0); e(0, 24'h011C0, 0, "reset_state");
    step(0, '0); e(0, 24'h011C0, 0, "reset_state2");
    reset_n = 1'b1;

    // lw: five microsteps back to fetch; duplicate lw entry must stay shadowed
    step(0, LW); e(1, 24'h03007, 0, "lw_decode");
    step(0, LW); e(2, 24'h06001, 0, "lw_addr");
    step(0, LW); e(3, 24'h00108, 0, "lw_mem");
    step(0, LW); e(4, 24'h28000, 0, "lw_wb");
    step(0, LW); e(0, 24'h011C0, 0, "lw_done");

    // sw with a 3-cycle stall on the memory-write word
    step(0, SW); e(1, 24'h03007, 0, "sw_decode");
    step(0, SW); e(5, 24'h06001, 0, "sw_addr");
    step(1, SW); e(6, 24'h00008, 0, "sw_stall1");
    step(1, SW); e(6, 24'h00008, 0, "sw_stall2");
    step(1, SW); e(6, 24'h00008, 0, "sw_stall3");
    step(0, SW); e(6, 24'h00208, 0, "sw_release");
    step(0, SW); e(0, 24'h011C0, 0, "sw_done");

    // illegal opcode: trap, flag held through a stall, then fetch
    step(0, BAD); e(1, 24'h03007, 0, "bad_decode");
    step(1, BAD); e(31, 24'h00050, 1, "bad_trap");
    step(0, BAD); e(31, 24'h00050, 1, "bad_trap_held");
    step(0, BAD); e(0, 24'h011C0, 0, "bad_fetch");

    // stall during dispatch: opcode present on release decides
    step(1, BAD); e(1, 24'h03007, 0, "disp_stall1");
    step(1, BAD); e(1, 24'h03007, 0, "disp_stall2");
    step(0, RR);  e(1, 24'h03007, 0, "disp_release");
    step(0, RR);  e(7, 24'h04801, 0, "r_exec");
    step(0, RR);  e(8, 24'h20000, 0, "r_wb");
    step(0, RR);  e(0, 24'h011C0, 0, "r_done");

    step(0, BEQ); e(1, 24'h03007, 0, "beq_decode");
    step(0, BEQ); e(10, 24'h04430, 0, "beq_exec");
    step(0, BEQ); e(0, 24'h011C0, 0, "beq_done");

    step(0, II); e(1, 24'h03007, 0, "i_decode");
    step(0, II); e(9, 24'h06C01, 0, "i_exec");
    step(0, II); e(8, 24'h20000, 0, "i_wb");
    step(0, II); e(0, 24'h011C0, 0, "i_done");

    // jal: 6-bit store reaches word 63 and wraps; 5-bit store folds onto the trap word
    step(0, JAL); e(1, 24'h03007, 0, "jal_decode");
    step(0, JAL); e(11, 24'h30050, 0, "jal_exec");
    step(0, JAL); e1(1'b0, 31, 24'h00050, 0, "jal_tail5"); e1(1'b1, 63, 24'h00001, 0, "jal_tail6");
    step(0, JAL); e(0, 24'h011C0, 0, "jal_wrap");

    // async reset mid-instruction at upc 6
    step(0, SW); e(1, 24'h03007, 0, "rst6_decode");
    step(0, SW); e(5, 24'h06001, 0, "rst6_addr");
    step(0, SW); e(6, 24'h00208, 0, "rst6_at6");
    async_reset("rst_at6");

    // async reset while illegal_op is set
    step(0, BAD); e(1, 24'h03007, 0, "rsttrap_decode");
    step(1, BAD); e(31, 24'h00050, 1, "rsttrap_trap");
    async_reset("rst_at_trap");

`ifdef UCODE_LOADABLE_EN
    // overwrite the current word while stalled, then confirm reset restores it
    step(1, LW); e1(1'b1, 1, 24'h03007, 0, "ld_before");
    ld_en = 1'b1; ld_addr = 6'd1; ld_data = {24'hABCDEF, 2'b01, 6'd3};
    step(1, LW); e1(1'b1, 1, 24'hA9CDEF, 0, "ld_seen_masked");
    ld_en = 1'b0;
    step(0, LW); e1(1'b1, 1, 24'hABCDEF, 0, "ld_seen");
    step(0, LW); e1(1'b1, 3, 24'h00108, 0, "ld_jump3");
    step(0, LW); e1(1'b1, 4, 24'h28000, 0, "ld_wb");
    step(0, LW); e1(1'b1, 0, 24'h011C0, 0, "ld_done");
    async_reset("ld_reset");
    step(0, LW); e(1, 24'h03007, 0, "ld_restored");
    step(0, LW); e(2, 24'h06001, 0, "ld_restored_disp");
`endif

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Parametrised microcoded control unit for the multi-cycle RISC-V CPU. It holds a micro-program counter (uPC), reads a wide microword from an internal microcode store and emits the datapath control word. It computes the next uPC from a per-word sequencing field: increment, jump, opcode dispatch or return-to-fetch. It replaces the fixed state-indexed control lookup and sits between the instruction register (opcode) and the datapath enables/selects.

## Interface
- `UADDR_W`, default 5: uPC width; store depth is 2**UADDR_W.
- `CTRL_W`, default 18: control-word width driven to the datapath.
- `OP_W`, default 7: opcode width.
- `TRAP_ADDR`, default 31: uPC entered on a dispatch miss.
- `WE_MASK`, default 18'b100000001000000000: control bits forced to 0 while `stall` is high (register/memory write enables).
- `clk`, input, 1: clock, rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `opcode`, input, OP_W: opcode from the instruction register; sampled only on dispatch.
- `stall`, input, 1: memory/wait handshake; holds the uPC.
- `ctrl`, output, CTRL_W: datapath control word.
- `upc`, output, UADDR_W: current micro-address (debug/trace).
- `fetch`, output, 1: high when `upc == 0`, i.e. at instruction start.
- `illegal_op`, output, 1: dispatch-miss indication.

## Operation
- Microword = {ctrl[CTRL_W], seq[2], next[UADDR_W]}, 25 bits by default.
- seq encodings:
  - 00 NEXT: uPC+1, modulo depth; wraps to 0.
  - 01 JUMP: `next`.
  - 10 DISP: dispatch-table lookup on `opcode`.
  - 11 FETCH: 0.
- Dispatch table: DISP_N entries {valid, opcode, target}, searched combinationally; the lowest index wins on duplicates.
- Dispatch miss goes to TRAP_ADDR. The trap microword must be JUMP/FETCH.
- `ctrl` = store[upc].ctrl & ~(stall ? WE_MASK : 0). Non-masked bits stay valid during a stall.
- Store entries not defined by the init constant = {ctrl 0, FETCH, next 0}.
- `illegal_op` is set on the clock edge that loads TRAP_ADDR because of a miss. It clears on the next uPC advance and is held while `stall` is high.

## Timing
- Reset (async assert, sync-safe deassert): upc = 0, illegal_op = 0. `ctrl` shows store[0].ctrl, `fetch` = 1.
- uPC updates only on rising `clk` with `stall` = 0. With `stall` = 1, upc and illegal_op hold.
- `ctrl`, `fetch` are combinational from upc and `stall` (0-cycle latency from upc). Next-uPC logic sees `opcode` in the same cycle.
- One microstep per unstalled cycle. Dispatch adds no extra cycle.
- `stall` asserted in a DISP cycle: the lookup is repeated each cycle and the `opcode` present on release is used.
- reset_n low mid-instruction: upc = 0 immediately (async), any pending dispatch is discarded.

## Configuration
- `UCODE_LOADABLE_EN` defined:
  - The store is a writable register array initialised from the package constant at reset.
  - Adds ports `load_en` (1), `load_addr` (UADDR_W) and `load_data` (CTRL_W+2+UADDR_W).
  - A write commits on the rising edge. A write to the current upc is seen on `ctrl` from the next cycle.
  - Writes are accepted regardless of `stall`.
  - Reset restores init contents.
- Undefined: the store is a constant ROM and the load ports do not exist.

## Structure
- Package `ucode_pkg`:
  - seq_e enum (NEXT/JUMP/DISP/FETCH).
  - microword struct typedef.
  - RISC-V opcode constants (lw 0000011, sw 0100011, R 0110011, I 0010011, jal 1101111, beq 1100011).
  - UCODE_INIT array.
  - DISP_TABLE constant, DISP_N.
- Sub-module `ucode_dispatch`: combinational opcode to {hit, target} lookup over DISP_TABLE.

## Test plan
- Reset with reset_n = 0 mid-run at upc = 6 → upc = 0 within the same cycle, fetch = 1, illegal_op = 0.
- lw (0000011), no stall: upc 0→1→dispatch target→… → returns to 0. ctrl matches UCODE_INIT at each step; cycle count equals the program length.
- stall held 3 cycles at a memory-write word → upc unchanged for 3 cycles, WE_MASK bits of ctrl = 0, other bits unchanged; advances on the first cycle with stall = 0.
- opcode 1111111 at dispatch → upc = 31 next cycle, illegal_op = 1 for one cycle, then FETCH to 0.
- NEXT at upc = 31 (UADDR_W = 5) → wraps to 0. Rerun with UADDR_W = 6, CTRL_W = 24: same program, correct widths.
- `UCODE_LOADABLE_EN`: write {ctrl 24'hABCDEF, JUMP, next 3} to the current upc → ctrl = 24'hABCDEF from the next cycle, then the jump to 3. After reset, the original contents are restored.
